// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end:
// fetch-queue entry layout, exception codes and the fetch FSM states.
package ifetch_pkg;

  localparam logic [31:0] NOP                 = 32'h0000_0013;
  localparam logic [3:0]  EXC_INSN_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSN_ACCESS     = 4'd1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  // Value presented toward decode when nothing valid is at the head.
  function automatic fetch_entry_t idle_entry();
    fetch_entry_t e;
    e.instr    = NOP;
    e.pc       = 64'h0;
    e.exc_en   = 1'b0;
    e.exc_code = 4'h0;
    e.exc_val  = 64'h0;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer with simultaneous push/pop and flush.
// Only the pointers are reset; entry storage is plain data.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // When full and popping, the write slot is the head being retired this edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_comb begin
    head  = mem[rd_ptr[AW-1:0]];
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, RUN/FAULT FSM and fetch-fire logic feeding ifetch_fifo.
// Optional IFETCH_BYPASS_EN forwards a fetch straight to decode when the queue is empty.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [63:0]  pc;
  logic [63:0]  pc_nxt;

  fetch_entry_t fetch_entry;
  fetch_entry_t head;
  fetch_entry_t out_entry;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  logic         head_pop;
  logic         fire;
  logic         misaligned;
  logic         bypass;

  assign pc_addr    = pc;
  assign misaligned = (pc[1:0] != 2'b00);

  // A misaligned PC never consults memory, so it outranks an imem fault.
  always_comb begin
    fetch_entry.pc = pc;
    if (misaligned) begin
      fetch_entry.instr    = NOP;
      fetch_entry.exc_en   = 1'b1;
      fetch_entry.exc_code = EXC_INSN_MISALIGNED;
      fetch_entry.exc_val  = pc;
    end else if (imem_exc_en) begin
      fetch_entry.instr    = NOP;
      fetch_entry.exc_en   = 1'b1;
      fetch_entry.exc_code = imem_exc_code;
      fetch_entry.exc_val  = imem_exc_val;
    end else begin
      fetch_entry.instr    = instruction;
      fetch_entry.exc_en   = 1'b0;
      fetch_entry.exc_code = 4'h0;
      fetch_entry.exc_val  = 64'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_en)                     state_nxt = ST_RUN;
    else if (fire && fetch_entry.exc_en) state_nxt = ST_FAULT;
  end

  // head_pop is independent of fire, so the bypass path forms no loop.
  always_comb begin
    head_pop = out_ready && !fifo_empty;
    fire     = (state == ST_RUN) && !redirect_en && (!fifo_full || head_pop);
    fifo_pop = head_pop && !redirect_en;
`ifdef IFETCH_BYPASS_EN
    bypass    = fire && fifo_empty;
    fifo_push = fire && !(bypass && out_ready);
`else
    bypass    = 1'b0;
    fifo_push = fire;
`endif
    if (redirect_en)                      pc_nxt = redirect_pc;
    else if (fire && !fetch_entry.exc_en) pc_nxt = pc + 64'd4;
    else                                  pc_nxt = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_nxt;
  end

  ifetch_fifo #(
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_en),
    .push     (fifo_push),
    .push_data(fetch_entry),
    .pop      (fifo_pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_entry = head;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_entry = fetch_entry;
    end else begin
      out_valid = 1'b0;
      out_entry = idle_entry();
    end
  end

  assign out_instr    = out_entry.instr;
  assign out_pc       = out_entry.pc;
  assign out_exc_en   = out_entry.exc_en;
  assign out_exc_code = out_entry.exc_code;
  assign out_exc_val  = out_entry.exc_val;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch (default build): memory model of 0x4000 bytes,
// faults reported beyond it; expected values are hand-derived per cycle.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .pc_addr      (pc_addr),
    .instruction  (instruction),
    .imem_exc_en  (imem_exc_en),
    .imem_exc_code(imem_exc_code),
    .imem_exc_val (imem_exc_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_exc_en   (out_exc_en),
    .out_exc_code (out_exc_code),
    .out_exc_val  (out_exc_val)
  );

  // Word k holds "addi x(k+1), x0, k+1": 0x00100093, 0x00200113, ...
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [11:0] n;
    n = a[13:2] + 12'd1;
    return ({20'h0, n} << 20) | ({27'h0, n[4:0]} << 7) | 32'h13;
  endfunction

  always_comb begin
    if (pc_addr < 64'h4000) begin
      instruction   = mem_word(pc_addr);
      imem_exc_en   = 1'b0;
      imem_exc_code = 4'd0;
      imem_exc_val  = 64'h0;
    end else begin
      instruction   = 32'h0;
      imem_exc_en   = 1'b1;
      imem_exc_code = 4'd1;
      imem_exc_val  = pc_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {63'h0, out_valid}, 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, {32'h0, out_instr}, {32'h0, ins});
    chk({tag, "_exc"}, {63'h0, out_exc_en}, 64'd0);
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    step();
    redirect_en = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 64'h0;
    out_ready   = 1'b1;
    step();
    step();
    chk("rst_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_instr", {32'h0, out_instr}, 64'h13);
    chk("rst_pc", out_pc, 64'h0);
    chk("rst_exc", {63'h0, out_exc_en}, 64'd0);
    chk("rst_pcaddr", pc_addr, 64'h0);
    rst = 1'b0;

    // Streaming with out_ready=1: one instruction per cycle from cycle 1.
    for (int i = 0; i < 4; i++) begin
      step();
      chk_head("stream", 64'(4 * i), mem_word(64'(4 * i)));
    end

    // Backpressure from reset: queue fills to 2, PC freezes at 8.
    rst       = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("hold", 64'h0, mem_word(64'h0));
    end
    chk("hold_pcaddr", pc_addr, 64'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("drain", 64'(4 * (i + 1)), mem_word(64'(4 * (i + 1))));
    end

    // Redirect while full and popping: flush wins.
    do_redirect(64'h80);
    chk("redir_valid", {63'h0, out_valid}, 64'd0);
    chk("redir_pcaddr", pc_addr, 64'h80);
    step();
    chk_head("redir_head", 64'h80, mem_word(64'h80));
    step();
    chk_head("redir_next", 64'h84, mem_word(64'h84));

    // Misaligned target: one exception entry, then silence until redirect.
    do_redirect(64'h102);
    chk("mis_valid0", {63'h0, out_valid}, 64'd0);
    chk("mis_pcaddr0", pc_addr, 64'h102);
    step();
    chk("mis_valid", {63'h0, out_valid}, 64'd1);
    chk("mis_exc", {63'h0, out_exc_en}, 64'd1);
    chk("mis_code", {60'h0, out_exc_code}, 64'd0);
    chk("mis_val", out_exc_val, 64'h102);
    chk("mis_instr", {32'h0, out_instr}, 64'h13);
    chk("mis_pc", out_pc, 64'h102);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mis_quiet", {63'h0, out_valid}, 64'd0);
      chk("mis_pchold", pc_addr, 64'h102);
    end
    do_redirect(64'h100);
    chk("mis_rec_pcaddr", pc_addr, 64'h100);
    step();
    chk_head("mis_rec", 64'h100, mem_word(64'h100));

    // Run off the end of memory: access fault at 0x4000.
    do_redirect(64'h3ff8);
    chk("acc_pcaddr0", pc_addr, 64'h3ff8);
    step();
    chk_head("acc_h0", 64'h3ff8, mem_word(64'h3ff8));
    step();
    chk_head("acc_h1", 64'h3ffc, mem_word(64'h3ffc));
    chk("acc_pcaddr1", pc_addr, 64'h4000);
    step();
    chk("acc_valid", {63'h0, out_valid}, 64'd1);
    chk("acc_exc", {63'h0, out_exc_en}, 64'd1);
    chk("acc_code", {60'h0, out_exc_code}, 64'd1);
    chk("acc_val", out_exc_val, 64'h4000);
    chk("acc_instr", {32'h0, out_instr}, 64'h13);
    chk("acc_pc", out_pc, 64'h4000);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("acc_quiet", {63'h0, out_valid}, 64'd0);
      chk("acc_pchold", pc_addr, 64'h4000);
    end

    // Reset overrides a simultaneous redirect with two entries queued.
    do_redirect(64'h0);
    out_ready = 1'b0;
    step();
    step();
    chk_head("pre_rst", 64'h0, mem_word(64'h0));
    rst         = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 64'h200;
    step();
    rst         = 1'b0;
    redirect_en = 1'b0;
    chk("mrst_valid", {63'h0, out_valid}, 64'd0);
    chk("mrst_pcaddr", pc_addr, 64'h0);
    chk("mrst_instr", {32'h0, out_instr}, 64'h13);
    out_ready = 1'b1;
    step();
    chk_head("mrst_run", 64'h0, mem_word(64'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_0000_0000, PC loaded on reset.
REQ-002 Parameter QDEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 redirect_en  in  1  load redirect_pc and flush the queue (branch/trap/mret).
REQ-006 redirect_pc  in  64  redirect target.
REQ-007 pc_addr  out  64  fetch address to instruction memory; equals PC register.
REQ-008 instruction  in  32  combinational instruction-memory read data for pc_addr.
REQ-009 imem_exc_en / imem_exc_code / imem_exc_val  in  1/4/64  instruction-memory access-fault report for pc_addr.
REQ-010 out_valid  out  1  queue head valid toward decode.
REQ-011 out_ready  in  1  decode accepts head.
REQ-012 out_instr / out_pc  out  32/64  head instruction and its PC.
REQ-013 out_exc_en / out_exc_code / out_exc_val  out  1/4/64  head exception tag (mcause code, mtval).

Function
REQ-014 Fetch fire = state RUN and !redirect_en and (queue not full or pop this cycle); on fire push {instruction, pc_addr, imem_exc_*} and PC <= PC + 4 (64-bit wrap).
REQ-015 Pop = out_valid and out_ready; head advances next edge.
REQ-016 Latency: instruction fetched in cycle N appears at out_* in cycle N+1 (without IFETCH_BYPASS_EN).
REQ-017 Full and pop in same cycle: push and pop both occur, occupancy unchanged.
REQ-018 Empty: out_valid=0, out_instr=32'h00000013, out_pc=0, out_exc_*=0.
REQ-019 redirect_en has priority over fetch, push and pop: next edge queue empty, PC <= redirect_pc, state <= RUN; same-cycle pop is discarded.
REQ-020 PC[1:0]!=0 in RUN: no memory use; push NOP entry with exc_en=1, code=0 (misaligned), val=PC; state <= FAULT.
REQ-021 imem_exc_en=1 on fire: pushed entry carries instruction=NOP, exc_en=1, code/val from imem; state <= FAULT; PC not incremented.
REQ-022 States: RUN (fetching), FAULT (no fetch, queue still drains); FAULT -> RUN only via redirect_en; exactly one exception entry per fault.
REQ-023 out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-024 On rst: PC=RESET_PC, queue empty, state RUN, all out_* at REQ-018 values.
REQ-025 rst mid-operation overrides redirect_en and any push/pop that cycle.

Configuration
REQ-026 Macro IFETCH_BYPASS_EN defined: empty queue with fetch fire forwards the fetched entry combinationally to out_* (out_valid=1 same cycle); if out_ready=1 it is not pushed.
REQ-027 IFETCH_BYPASS_EN undefined: no combinational path from instruction/imem_exc_* to out_*; REQ-016 latency holds.

Structure
REQ-028 Package ifetch_pkg holds NOP constant 32'h00000013, EXC_INSN_MISALIGNED=4'd0, EXC_INSN_ACCESS=4'd1, and fetch-entry typedef {instr, pc, exc_en, exc_code, exc_val}.
REQ-029 Queue is sub-module ifetch_fifo (parameter DEPTH, push/pop/flush, full/empty); ifetch holds PC, FSM and fire logic.

Verification
REQ-030 Reset with RESET_PC=0x0, out_ready=1, memory words 0..3 = 0x00100093,0x00200113,... -> out_pc 0,4,8,12 on consecutive cycles from cycle 1.
REQ-031 out_ready=0 for 5 cycles -> exactly QDEPTH entries held, pc_addr frozen at RESET_PC+4*QDEPTH, head unchanged; release -> in-order drain, no loss/duplication.
REQ-032 redirect_en with redirect_pc=0x80 while queue full and out_ready=1 -> next cycle out_valid=0, pc_addr=0x80; following cycle out_pc=0x80.
REQ-033 redirect_pc=0x102 -> single entry out_exc_en=1, code=0, val=0x102, out_instr=0x13; no further entries until redirect_pc=0x100.
REQ-034 PC reaches 0x4000 (beyond memory), imem_exc_en=1 code=1 -> single entry code=1, val=0x4000; pc_addr holds 0x4000 in FAULT.
REQ-035 rst asserted while queue holds 2 entries and redirect_en=1 -> next cycle out_valid=0, pc_addr=RESET_PC, state RUN.
